// File: rtl/mem_map_pkg.sv
// mem_map_pkg: shared memory-map definitions for the CPU data bus.
//   region_t    : decoded target of a CPU data access (NONE/RAM/VRAM)
//   RAM_REGION  : cpu_address[31:28] value that selects general RAM
//   VRAM_REGION : cpu_address[31:28] value that selects video RAM
//   *_AW_DEF    : default RAM word / VRAM byte address widths
package mem_map_pkg;
    typedef enum logic [1:0] {NONE, RAM, VRAM} region_t;
    localparam logic [3:0] RAM_REGION  = 4'h0;
    localparam logic [3:0] VRAM_REGION = 4'hF;
    localparam int RAM_AW_DEF  = 12;
    localparam int VRAM_AW_DEF = 16;
endpackage

// File: rtl/addr_decode.sv
// addr_decode: combinational CPU address to memory region decoder.
//   cpu_address : in  32-bit CPU byte address
//   region      : out decoded region (NONE when the top nibble is unmapped)
module addr_decode
    import mem_map_pkg::*;
(
    input  logic [31:0] cpu_address,
    output region_t     region
);
    // Only the top nibble takes part in the decode.
    logic unused_low;
    assign unused_low = &{1'b0, cpu_address[27:0]};

    always_comb begin
        region = cpu_address[31:28] == VRAM_REGION ? VRAM :
                 cpu_address[31:28] == RAM_REGION  ? RAM  : NONE;
    end
endmodule

// File: rtl/mem_bus.sv
// mem_bus: routes CPU data-port accesses to RAM or VRAM and returns read data
// one cycle after the address, matching the synchronous-read memories.
//   clk, rst_n   : clock, asynchronous active-low reset
//   mem_w        : in  CPU write strobe
//   cpu2bus      : in  CPU write data
//   cpu_address  : in  CPU byte address
//   vram2bus     : in  VRAM read byte
//   ram2bus      : in  RAM read word
//   ram_w/vram_w : out write enables (at most one high, none when unmapped)
//   bus2cpu      : out read data steered by the previous cycle's region
//   bus2ram      : out RAM write data
//   bus2vram     : out VRAM write byte
//   ram_address  : out RAM word address
//   vram_address : out VRAM byte address
//   bus_err      : out sticky unmapped-write flag, only when BUS_ERR_EN is defined
module mem_bus
    import mem_map_pkg::*;
#(
    parameter int RAM_AW  = RAM_AW_DEF,
    parameter int VRAM_AW = VRAM_AW_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mem_w,
    input  logic [31:0]        cpu2bus,
    input  logic [31:0]        cpu_address,
    input  logic [7:0]         vram2bus,
    input  logic [31:0]        ram2bus,
    output logic               ram_w,
    output logic               vram_w,
    output logic [31:0]        bus2cpu,
    output logic [31:0]        bus2ram,
    output logic [7:0]         bus2vram,
    output logic [RAM_AW-1:0]  ram_address,
    output logic [VRAM_AW-1:0] vram_address
`ifdef BUS_ERR_EN
    ,
    output logic               bus_err
`endif
);
    region_t region;
    region_t sel_q;

    addr_decode u_decode (
        .cpu_address(cpu_address),
        .region     (region)
    );

    assign ram_address  = cpu_address[RAM_AW+1:2];
    assign vram_address = cpu_address[VRAM_AW-1:0];
    assign bus2ram      = cpu2bus;
    assign bus2vram     = cpu2bus[7:0];
    assign ram_w        = mem_w && region == RAM;
    assign vram_w       = mem_w && region == VRAM;

    // Remembers which memory was addressed so its synchronous read data can
    // be steered back on the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sel_q <= NONE;
        else        sel_q <= region;
    end

    always_comb begin
        bus2cpu = sel_q == RAM  ? ram2bus :
                  sel_q == VRAM ? {24'b0, vram2bus} : 32'h0;
    end

`ifdef BUS_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       bus_err <= 1'b0;
        else if (mem_w && region == NONE) bus_err <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_mem_bus.sv
// tb_mem_bus: randomized and directed checks of mem_bus against a memory-map model.
module tb_mem_bus;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_w;
    logic [31:0] cpu2bus;
    logic [31:0] cpu_address;
    logic [7:0]  vram2bus;
    logic [31:0] ram2bus;
    logic        ram_w;
    logic        vram_w;
    logic [31:0] bus2cpu;
    logic [31:0] bus2ram;
    logic [7:0]  bus2vram;
    logic [11:0] ram_address;
    logic [15:0] vram_address;
`ifdef BUS_ERR_EN
    logic        bus_err;
`endif

    int n_checks = 0;
    int n_fails  = 0;
    int prev_reg = 0;      // 0 = unmapped, 1 = RAM, 2 = VRAM
    bit err_model = 1'b0;

    always #5 clk = ~clk;

    mem_bus dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_w       (mem_w),
        .cpu2bus     (cpu2bus),
        .cpu_address (cpu_address),
        .vram2bus    (vram2bus),
        .ram2bus     (ram2bus),
        .ram_w       (ram_w),
        .vram_w      (vram_w),
        .bus2cpu     (bus2cpu),
        .bus2ram     (bus2ram),
        .bus2vram    (bus2vram),
        .ram_address (ram_address),
        .vram_address(vram_address)
`ifdef BUS_ERR_EN
        ,
        .bus_err     (bus_err)
`endif
    );

    function automatic int region_of(input logic [31:0] a);
        int top;
        top = int'(a / 32'h1000_0000);
        return top == 15 ? 2 : top == 0 ? 1 : 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Called just after a falling edge: drives one cycle of inputs, checks all
    // outputs, advances the model across the coming rising edge.
    task automatic apply(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic [31:0] r, input logic [7:0] v);
        int rg;
        logic [31:0] exp_rd;
        cpu_address = a; mem_w = w; cpu2bus = d; ram2bus = r; vram2bus = v;
        #1;
        rg = region_of(a);
        exp_rd = prev_reg == 1 ? r : prev_reg == 2 ? {24'h0, v} : 32'h0;
        check("ram_w", {31'b0, ram_w}, {31'b0, w && rg == 1});
        check("vram_w", {31'b0, vram_w}, {31'b0, w && rg == 2});
        check("ram_address", {20'b0, ram_address}, (a / 4) % 4096);
        check("vram_address", {16'b0, vram_address}, a % 65536);
        check("bus2ram", bus2ram, d);
        check("bus2vram", {24'b0, bus2vram}, d % 256);
        check("bus2cpu", bus2cpu, exp_rd);
`ifdef BUS_ERR_EN
        check("bus_err", {31'b0, bus_err}, {31'b0, err_model});
`endif
        if (!rst_n) begin
            prev_reg = 0;
            err_model = 1'b0;
        end else begin
            prev_reg = rg;
            if (w && rg == 0) err_model = 1'b1;
        end
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] a, r;
        int pick;
        rst_n = 1'b0; mem_w = 1'b0; cpu2bus = '0; cpu_address = '0;
        vram2bus = '0; ram2bus = 32'h1234_5678;
        @(negedge clk);
        // Held in reset: read data stays zero even with a RAM address present.
        apply(32'h0000_0F12, 1'b0, 32'h0, 32'h1234_5678, 8'h00);
        rst_n = 1'b1;
        apply(32'h0000_0F12, 1'b0, 32'h0, 32'h1234_5678, 8'h00);
        apply(32'h0000_0F12, 1'b0, 32'h0, 32'h1234_5678, 8'h00);
        check("first_ram_read", bus2cpu, 32'h1234_5678);
        // Directed writes and reads.
        apply(32'hF000_0012, 1'b1, 32'h0000_0FFF, 32'h1234_5678, 8'h00);
        apply(32'h0000_0F12, 1'b1, 32'h0000_0FFF, 32'h1234_5678, 8'h00);
        apply(32'hF000_0000, 1'b0, 32'h0, 32'hDEAD_BEEF, 8'hA5);
        apply(32'h8000_0000, 1'b1, 32'h5555_AAAA, 32'hDEAD_BEEF, 8'hA5);
        apply(32'h8000_0000, 1'b0, 32'h0, 32'hDEAD_BEEF, 8'hA5);
        check("unmapped_read_zero", bus2cpu, 32'h0);
        // Back-to-back region changes.
        apply(32'h0000_0004, 1'b0, 32'h0, 32'h1111_1111, 8'h3C);
        apply(32'hF000_0004, 1'b0, 32'h0, 32'h2222_2222, 8'h4D);
        apply(32'h0000_0008, 1'b0, 32'h0, 32'h3333_3333, 8'h5E);
        apply(32'hF000_0008, 1'b0, 32'h0, 32'h4444_4444, 8'h6F);
        // Asynchronous reset in the middle of a RAM read.
        apply(32'h0000_0010, 1'b0, 32'h0, 32'h7777_7777, 8'h00);
        #2 rst_n = 1'b0;
        #1 check("async_reset_read", bus2cpu, 32'h0);
        prev_reg = 0; err_model = 1'b0;
        @(negedge clk);
        apply(32'h0000_0010, 1'b0, 32'h0, 32'h7777_7777, 8'h00);
        rst_n = 1'b1;
        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            a = $urandom();
            pick = $urandom_range(0, 2);
            if (pick == 0) a = {4'h0, a[27:0]};
            else if (pick == 1) a = {4'hF, a[27:0]};
            r = $urandom();
            apply(a, 1'($urandom_range(0, 1)), $urandom(), r, 8'($urandom()));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
